// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The slave modport is the arbiter's view; the master modport is the environment's.
interface dmem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_W = DATA_WIDTH / 8;

  logic                  core_req_i;
  logic                  core_we_i;
  logic [BE_W-1:0]       core_be_i;
  logic [ADDR_WIDTH-1:0] core_addr_i;
  logic [DATA_WIDTH-1:0] core_wdata_i;
  logic                  core_gnt_o;
  logic                  core_rvalid_o;
  logic [DATA_WIDTH-1:0] core_rdata_o;
  logic                  core_stall_o;

  logic                  dma_req_i;
  logic                  dma_we_i;
  logic [BE_W-1:0]       dma_be_i;
  logic [ADDR_WIDTH-1:0] dma_addr_i;
  logic [DATA_WIDTH-1:0] dma_wdata_i;
  logic                  dma_gnt_o;
  logic                  dma_rvalid_o;
  logic [DATA_WIDTH-1:0] dma_rdata_o;

  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_wdata_o;
  logic [BE_W-1:0]       mem_wen_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;

  modport slave (
    input  core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
    input  dma_req_i, dma_we_i, dma_be_i, dma_addr_i, dma_wdata_i,
    output dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    output mem_addr_o, mem_wdata_o, mem_wen_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_we_i, core_be_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_stall_o,
    output dma_req_i, dma_we_i, dma_be_i, dma_addr_i, dma_wdata_i,
    input  dma_gnt_o, dma_rvalid_o, dma_rdata_o,
    input  mem_addr_o, mem_wdata_o, mem_wen_o,
    output mem_rdata_i
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory arbiter: core has fixed priority, DMA is forced through
// after STARVE_LIMIT consecutive denied cycles. Read data returns one cycle later.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic                clk,
  input logic                rst,
  dmem_port_arbiter_if.slave bus
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_CORE = 2'd1;
  localparam logic [1:0] OWN_DMA  = 2'd2;

  logic [1:0] r_rd_owner;
  logic [3:0] r_starve_cnt;
  logic       w_force_dma;
  logic       w_dma_gnt;
  logic       w_core_gnt;
  logic       w_core_rvalid;
  logic       w_dma_rvalid;

  always_comb begin
    w_force_dma = (r_starve_cnt == LIMIT);
    w_dma_gnt   = ~rst & bus.dma_req_i & (~bus.core_req_i | w_force_dma);
    w_core_gnt  = ~rst & bus.core_req_i & ~w_dma_gnt;
  end

  // Memory is driven only by the winner; idle cycles present an all-zero bus.
  always_comb begin
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_wen_o   = '0;
    if (w_dma_gnt) begin
      bus.mem_addr_o  = bus.dma_addr_i;
      bus.mem_wdata_o = bus.dma_wdata_i;
      bus.mem_wen_o   = bus.dma_we_i ? bus.dma_be_i : '0;
    end else if (w_core_gnt) begin
      bus.mem_addr_o  = bus.core_addr_i;
      bus.mem_wdata_o = bus.core_wdata_i;
      bus.mem_wen_o   = bus.core_we_i ? bus.core_be_i : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_owner   <= OWN_NONE;
      r_starve_cnt <= '0;
    end else begin
      if (w_core_gnt && !bus.core_we_i)
        r_rd_owner <= OWN_CORE;
      else if (w_dma_gnt && !bus.dma_we_i)
        r_rd_owner <= OWN_DMA;
      else
        r_rd_owner <= OWN_NONE;

      if (!bus.dma_req_i || w_dma_gnt)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != LIMIT)
        r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_comb begin
    w_core_rvalid     = (r_rd_owner == OWN_CORE);
    w_dma_rvalid      = (r_rd_owner == OWN_DMA);
    bus.core_gnt_o    = w_core_gnt;
    bus.dma_gnt_o     = w_dma_gnt;
    bus.core_stall_o  = bus.core_req_i & ~w_core_gnt;
    bus.core_rvalid_o = w_core_rvalid;
    bus.dma_rvalid_o  = w_dma_rvalid;
    bus.core_rdata_o  = w_core_rvalid ? bus.mem_rdata_i : '0;
    bus.dma_rdata_o   = w_dma_rvalid ? bus.mem_rdata_i : '0;
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: write-first memory environment, directed scenarios,
// then random traffic checked against a request-level reference model.
module tb_dmem_port_arbiter;
  localparam int LIMIT = 4;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  dmem_port_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  dmem_port_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] seed_word(input int unsigned i);
    return (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Write-first synchronous memory, 256 words.
  logic [31:0] env_mem [256];
  logic [31:0] env_rdata;
  logic        env_seeded = 1'b0;
  assign bus.mem_rdata_i = env_rdata;

  always @(posedge clk) begin
    if (!env_seeded) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= seed_word(i);
      env_seeded <= 1'b1;
      env_rdata  <= '0;
    end else begin
      logic [31:0] w;
      w = env_mem[bus.mem_addr_o[9:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_wen_o[b]) w[8*b +: 8] = bus.mem_wdata_o[8*b +: 8];
      env_mem[bus.mem_addr_o[9:2]] <= w;
      env_rdata <= w;
    end
  end

  // Reference model state
  logic [31:0] ref_mem [256];
  int          streak;
  int          pend;
  logic [31:0] pend_data;
  logic        last_dg;
  logic        last_cg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic cr, input logic cw, input logic [3:0] cb,
                      input logic [31:0] ca, input logic [31:0] cd,
                      input logic dr, input logic dw, input logic [3:0] db,
                      input logic [31:0] da, input logic [31:0] dd);
    logic        eg_d, eg_c;
    logic [31:0] ea, ew;
    logic [3:0]  ewen;
    @(negedge clk);
    rst = r;
    bus.core_req_i = cr; bus.core_we_i = cw; bus.core_be_i = cb;
    bus.core_addr_i = ca; bus.core_wdata_i = cd;
    bus.dma_req_i = dr; bus.dma_we_i = dw; bus.dma_be_i = db;
    bus.dma_addr_i = da; bus.dma_wdata_i = dd;
    #1;
    eg_d = !r && dr && (!cr || streak >= LIMIT);
    eg_c = !r && cr && !eg_d;
    ea = '0; ew = '0; ewen = '0;
    if (eg_d) begin ea = da; ew = dd; ewen = dw ? db : 4'h0; end
    else if (eg_c) begin ea = ca; ew = cd; ewen = cw ? cb : 4'h0; end
    last_dg = bus.dma_gnt_o;
    last_cg = bus.core_gnt_o;
    chk("core_gnt", 32'(bus.core_gnt_o), 32'(eg_c));
    chk("dma_gnt", 32'(bus.dma_gnt_o), 32'(eg_d));
    chk("core_stall", 32'(bus.core_stall_o), 32'(cr && !eg_c));
    chk("mem_addr", bus.mem_addr_o, ea);
    chk("mem_wdata", bus.mem_wdata_o, ew);
    chk("mem_wen", 32'(bus.mem_wen_o), 32'(ewen));
    if (!r) begin
      chk("core_rvalid", 32'(bus.core_rvalid_o), 32'(pend == 1));
      chk("dma_rvalid", 32'(bus.dma_rvalid_o), 32'(pend == 2));
      chk("core_rdata", bus.core_rdata_o, (pend == 1) ? pend_data : 32'h0);
      chk("dma_rdata", bus.dma_rdata_o, (pend == 2) ? pend_data : 32'h0);
    end
    @(posedge clk);
    if (r) begin
      pend = 0;
      streak = 0;
    end else begin
      pend = 0;
      if (eg_c && !cw) begin pend = 1; pend_data = ref_mem[ca[9:2]]; end
      if (eg_d && !dw) begin pend = 2; pend_data = ref_mem[da[9:2]]; end
      for (int b = 0; b < 4; b++)
        if (ewen[b]) ref_mem[ea[9:2]][8*b +: 8] = ew[8*b +: 8];
      streak = (dr && !eg_d) ? ((streak + 1 > LIMIT) ? LIMIT : streak + 1) : 0;
    end
  endtask

  task automatic idle(input logic r);
    step(r, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  logic [9:0] pat;
  logic [4:0] drop_pat;

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
    streak = 0; pend = 0; pend_data = '0;
    rst = 1'b1;
    bus.core_req_i = 0; bus.core_we_i = 0; bus.core_be_i = '0;
    bus.core_addr_i = '0; bus.core_wdata_i = '0;
    bus.dma_req_i = 0; bus.dma_we_i = 0; bus.dma_be_i = '0;
    bus.dma_addr_i = '0; bus.dma_wdata_i = '0;

    // Reset then idle
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);

    // Core store then load of the same word
    step(1'b0, 1'b1, 1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #1;
    chk("raw_rvalid", 32'(bus.core_rvalid_o), 32'h1);
    chk("raw_rdata", bus.core_rdata_o, 32'hDEAD_BEEF);
    idle(1'b0);

    // Continuous contention
    pat = 10'b10_0001_0000;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h40 + 32'(4*i), 32'h0,
                 1'b1, 1'b0, 4'h0, 32'h80 + 32'(4*i), 32'h0);
      chk("contention_pattern", 32'(last_dg), 32'(pat[i]));
    end
    idle(1'b0);

    // Interleaved returns
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h20, 32'h0);
    idle(1'b0);
    idle(1'b0);

    // DMA drops its request while starving: counter restarts
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b0, 1'b0, 4'h0, 32'h34, 32'h0);
    drop_pat = 5'b1_0000;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 1'b0, 4'h0, 32'h30, 32'h0, 1'b1, 1'b0, 4'h0, 32'h34, 32'h0);
      chk("drop_restart", 32'(last_dg), 32'(drop_pat[i]));
    end
    idle(1'b0);

    // Reset while a read is outstanding
    step(1'b0, 1'b1, 1'b0, 4'h0, 32'h100, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 4'hF, 32'h100, 32'h1234_5678, 1'b1, 1'b1, 4'hF, 32'h104, 32'h0);
    #1;
    chk("rst_drop_rvalid", 32'(bus.core_rvalid_o), 32'h0);
    idle(1'b0);

    // Random traffic over a small address window to exercise read-after-write
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 59) == 0),
           ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
           32'($urandom_range(0, 15)) << 2, $urandom,
           ($urandom_range(0, 2) != 0), 1'($urandom), 4'($urandom),
           32'($urandom_range(0, 15)) << 2, $urandom);
      total++;
      assert (!(last_dg && last_cg)) else begin
        bad++;
        $error("FAIL both_gnt observed=%0d%0d expected=0", last_cg, last_dg);
      end
    end
    idle(1'b0);
    idle(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
